// File: rtl/park_transform_arbiter.sv
// park_transform_arbiter: shares one park_transform instance between NUM_REQ
// requesters. Round-robin grant into a one-deep issue register tagged with the
// requester index, credit-limited in-flight count, and channel-based routing
// of results back to the requesters.
// Build option PARK_ARB_PRIORITY_EN: requester 0 becomes strict high priority
// with one credit reserved for it; requesters 1..NUM_REQ-1 rotate among
// themselves.
module park_transform_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int RW = 10 + 2 * DATA_WIDTH,
    localparam int OW = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ*RW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [OW-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [RW-1:0]         pt_in_data,
    output logic [CW-1:0]         pt_in_channel,
    output logic                  pt_in_valid,
    input  logic                  pt_in_ready,
    input  logic [OW-1:0]         pt_out_data,
    input  logic [CW-1:0]         pt_out_channel,
    input  logic                  pt_out_valid,
    output logic                  pt_out_ready,
    output logic [3:0]            outstanding,
    output logic                  route_err
);

    localparam int NP = 1 << CW;

    logic          in_valid_q, in_valid_d;
    logic [RW-1:0] in_data_q, in_data_d;
    logic [CW-1:0] in_chan_q, in_chan_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [3:0]    count_q, count_d;
    logic          route_err_q, route_err_d;

    logic [NP-1:0] valid_pad;
    logic [NP-1:0] rsp_ready_pad;
    logic          may_load;
    logic          pending;
    logic [4:0]    used;
    logic          credit_ok;
    logic          found;
    logic [CW-1:0] win;
    logic [CW-1:0] cand;
    logic          hs;
    logic [RW-1:0] sel_data;
    logic          chan_ok;
    logic          dec;

    // Pad per-requester vectors to a power of two so a CW-bit index never
    // falls outside the vector.
    assign valid_pad     = NP'(req_valid);
    assign rsp_ready_pad = NP'(rsp_ready);

    // The register can take a new request when empty or when its current
    // request is leaving this cycle.
    assign may_load = !in_valid_q || pt_in_ready;

    // Occupancy seen by the credit check: the issued count already includes a
    // registered request; a stalled one is added on top.
    assign pending = in_valid_q && !pt_in_ready;
    assign used    = {1'b0, count_q} + 5'(pending);

`ifdef PARK_ARB_PRIORITY_EN
    logic [CW-1:0] ptr_eff;

    // Pointer value 0 (after reset) means "start the rotation at requester 1".
    assign ptr_eff = (ptr_q == '0) ? CW'(1) : ptr_q;

    // Grant search: requester 0 first, then rotate over 1..NUM_REQ-1 from the pointer.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        credit_ok = 1'b0;
        ptr_d     = ptr_q;
        if (req_valid[0]) begin
            found = 1'b1;
            win   = '0;
        end else begin
            for (int k = NUM_REQ - 2; k >= 0; k--) begin
                cand = CW'(((int'(ptr_eff) + NUM_REQ - 2 + k) % (NUM_REQ - 1)) + 1);
                if (valid_pad[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        if (win == '0) begin
            credit_ok = (used < 5'(MAX_OUTSTANDING));
        end else begin
            credit_ok = (used < 5'(MAX_OUTSTANDING - 1));
        end
        if (hs && (win != '0)) begin
            ptr_d = CW'((int'(win) % (NUM_REQ - 1)) + 1);
        end
    end
`else
    // Grant search: rotate over all requesters starting at the pointer.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        credit_ok = (used < 5'(MAX_OUTSTANDING));
        ptr_d     = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = CW'((int'(ptr_q) + k) % NUM_REQ);
            if (valid_pad[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (hs) begin
            ptr_d = CW'((int'(win) + 1) % NUM_REQ);
        end
    end
`endif

    assign hs = found && may_load && credit_ok;

    // One-hot ready for the winner and selection of its request word.
    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == CW'(i)) begin
                req_ready[i] = hs;
                sel_data     = req_data[i*RW +: RW];
            end
        end
    end

    // Result routing: illegal channels are accepted and dropped.
    always_comb begin
        chan_ok      = (int'(pt_out_channel) < NUM_REQ);
        rsp_valid    = '0;
        pt_out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = pt_out_valid && chan_ok && (pt_out_channel == CW'(i));
        end
        if (chan_ok) begin
            pt_out_ready = rsp_ready_pad[pt_out_channel];
        end
    end

    assign dec = pt_out_valid && pt_out_ready;

    // Next state of issue register, credit count and error flag.
    always_comb begin
        in_valid_d  = in_valid_q;
        in_data_d   = in_data_q;
        in_chan_d   = in_chan_q;
        count_d     = count_q;
        route_err_d = route_err_q;
        if (hs) begin
            in_valid_d = 1'b1;
            in_data_d  = sel_data;
            in_chan_d  = win;
        end else if (pt_in_ready) begin
            in_valid_d = 1'b0;
        end
        if (hs && !dec) begin
            count_d = count_q + 4'd1;
        end else if (!hs && dec) begin
            if (count_q == 4'd0) begin
                route_err_d = 1'b1;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
        if (pt_out_valid && !chan_ok) begin
            route_err_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_valid_q  <= 1'b0;
            ptr_q       <= '0;
            count_q     <= 4'd0;
            route_err_q <= 1'b0;
        end else begin
            in_valid_q  <= in_valid_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            route_err_q <= route_err_d;
        end
    end

    // Issue-register payload; qualified by in_valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        in_data_q <= in_data_d;
        in_chan_q <= in_chan_d;
    end

    assign pt_in_valid   = in_valid_q;
    assign pt_in_data    = in_data_q;
    assign pt_in_channel = in_chan_q;
    assign rsp_data      = pt_out_data;
    assign outstanding   = count_q;
    assign route_err     = route_err_q;

endmodule

// File: tb/tb_park_transform_arbiter.sv
// Directed bench for park_transform_arbiter: the bench plays park_transform
// on the stream ports. A second instance with NUM_REQ=5 provides a channel
// value that is representable but illegal.
module tb_park_transform_arbiter;

    localparam int N  = 4;
    localparam int RW = 42;
    localparam int OW = 32;
    localparam int NB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [N*RW-1:0] req_data;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [OW-1:0]   rsp_data;
    logic [RW-1:0]   pt_in_data;
    logic [1:0]      pt_in_channel;
    logic            pt_in_valid, pt_in_ready;
    logic [OW-1:0]   pt_out_data;
    logic [1:0]      pt_out_channel;
    logic            pt_out_valid, pt_out_ready;
    logic [3:0]      outstanding;
    logic            route_err;

    logic [NB*RW-1:0] b_req_data;
    logic [NB-1:0]    b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [OW-1:0]    b_rsp_data;
    logic [RW-1:0]    b_pt_in_data;
    logic [2:0]       b_pt_in_channel;
    logic             b_pt_in_valid, b_pt_in_ready;
    logic [OW-1:0]    b_pt_out_data;
    logic [2:0]       b_pt_out_channel;
    logic             b_pt_out_valid, b_pt_out_ready;
    logic [3:0]       b_outstanding;
    logic             b_route_err;

    park_transform_arbiter #(.NUM_REQ(N), .DATA_WIDTH(16), .MAX_OUTSTANDING(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .pt_in_data(pt_in_data), .pt_in_channel(pt_in_channel),
        .pt_in_valid(pt_in_valid), .pt_in_ready(pt_in_ready),
        .pt_out_data(pt_out_data), .pt_out_channel(pt_out_channel),
        .pt_out_valid(pt_out_valid), .pt_out_ready(pt_out_ready),
        .outstanding(outstanding), .route_err(route_err)
    );

    park_transform_arbiter #(.NUM_REQ(NB), .DATA_WIDTH(16), .MAX_OUTSTANDING(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_data(b_req_data), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .rsp_data(b_rsp_data), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .pt_in_data(b_pt_in_data), .pt_in_channel(b_pt_in_channel),
        .pt_in_valid(b_pt_in_valid), .pt_in_ready(b_pt_in_ready),
        .pt_out_data(b_pt_out_data), .pt_out_channel(b_pt_out_channel),
        .pt_out_valid(b_pt_out_valid), .pt_out_ready(b_pt_out_ready),
        .outstanding(b_outstanding), .route_err(b_route_err)
    );

    typedef struct {
        logic [3:0] rv;
        logic       pir;
        logic       pov;
        logic [1:0] poc;
        logic [3:0] rr;
        logic [3:0] e_rdy;
        logic [3:0] e_rspv;
        logic       e_por;
        logic       e_piv;
        logic [1:0] e_pic;
        logic [3:0] e_out;
    } vec_t;

    vec_t vecs[16];
    int   checks = 0;
    int   errs   = 0;

    function automatic logic [RW-1:0] mkreq(input int i);
        if (i == 1) return {1'b0, 9'd43, 16'd0, 16'hD8F0};
        return {i[0], 9'(100 + i), 16'(i * 1111 + 7), 16'(i * 2222 + 3)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        pt_out_valid = 1'b0;
        pt_in_ready  = 1'b1;
        rsp_ready    = '1;
        b_req_valid  = '0;
        b_pt_out_valid = 1'b0;
        reset_n      = 1'b0;
        cyc();
        reset_n      = 1'b1;
    endtask

    initial begin
        int hs_cnt;
        int grants[N];
        int repeats;
        int last;

        for (int i = 0; i < N; i++) req_data[i*RW +: RW] = mkreq(i);
        for (int i = 0; i < NB; i++) b_req_data[i*RW +: RW] = mkreq(i);
        pt_out_data     = 32'h1234_ABCD;
        pt_out_channel  = 2'd0;
        b_pt_out_data   = 32'h0;
        b_pt_out_channel = 3'd0;
        b_pt_in_ready   = 1'b1;
        b_rsp_ready     = '1;

        vecs[0]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 4'd1};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'd1};
        vecs[2]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd0, 4'd0};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'd1};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'd2};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 4'd3};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 4'd4};
        vecs[7]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0, 4'd4};
        vecs[8]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd0, 4'd3};
        vecs[9]  = '{4'b0001, 1'b1, 1'b1, 2'd3, 4'b1000, 4'b0001, 4'b1000, 1'b1, 1'b1, 2'd0, 4'd3};
        vecs[10] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'd2};
        vecs[11] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 4'd2};
        vecs[12] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'd3};
        vecs[13] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd0, 4'd2};
        vecs[14] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd1};
        vecs[15] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd0, 4'd0};

        // Reset state
        do_reset();
        cyc();
        chk("rst_pt_in_valid", pt_in_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_route_err", route_err, 0);
        chk("rst_req_ready", req_ready, 0);

        // Table: basic issue, rotation, back-pressure on results, credit return
        for (int i = 0; i < 16; i++) begin
            req_valid      = vecs[i].rv;
            pt_in_ready    = vecs[i].pir;
            pt_out_valid   = vecs[i].pov;
            pt_out_channel = vecs[i].poc;
            rsp_ready      = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("row%0d_req_ready", i), req_ready, vecs[i].e_rdy);
            chk($sformatf("row%0d_rsp_valid", i), rsp_valid, vecs[i].e_rspv);
            chk($sformatf("row%0d_pt_out_ready", i), pt_out_ready, vecs[i].e_por);
            chk($sformatf("row%0d_rsp_data", i), rsp_data, 32'h1234_ABCD);
            cyc();
            chk($sformatf("row%0d_pt_in_valid", i), pt_in_valid, vecs[i].e_piv);
            chk($sformatf("row%0d_outstanding", i), outstanding, vecs[i].e_out);
            if (vecs[i].e_piv) begin
                chk($sformatf("row%0d_pt_in_channel", i), pt_in_channel, vecs[i].e_pic);
                chk($sformatf("row%0d_pt_in_data", i), pt_in_data, mkreq(int'(vecs[i].e_pic)));
            end
        end

        // Fairness: all requesters valid for 16 cycles, results returned in order
        do_reset();
        for (int j = 0; j < N; j++) grants[j] = 0;
        repeats = 0;
        last = -1;
        for (int k = 0; k < 16; k++) begin
            req_valid      = 4'b1111;
            pt_in_ready    = 1'b1;
            rsp_ready      = 4'b1111;
            pt_out_valid   = (k > 0);
            pt_out_channel = 2'((k + 3) % 4);
            @(negedge clk);
            chk($sformatf("fair%0d_req_ready", k), req_ready, 4'b0001 << (k % 4));
            for (int j = 0; j < N; j++) begin
                if (req_ready[j]) begin
                    grants[j]++;
                    if (j == last) repeats++;
                    last = j;
                end
            end
            cyc();
        end
        for (int j = 0; j < N; j++) chk($sformatf("fair_grants%0d", j), grants[j], 4);
        chk("fair_repeats", repeats, 0);
        chk("fair_outstanding", outstanding, 1);

        // Credit limit: results blocked by rsp_ready=0
        do_reset();
        req_valid      = 4'b1111;
        pt_in_ready    = 1'b1;
        pt_out_valid   = 1'b1;
        pt_out_channel = 2'd0;
        rsp_ready      = 4'b0000;
        hs_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hs_cnt += $countones(req_ready & req_valid);
            if (k == 0) chk("credit_pt_out_ready_low", pt_out_ready, 0);
            cyc();
        end
        chk("credit_handshakes", hs_cnt, 8);
        chk("credit_outstanding_full", outstanding, 8);
        rsp_ready = 4'b0001;
        @(negedge clk);
        chk("credit_full_req_ready", req_ready, 0);
        chk("credit_release_pt_out_ready", pt_out_ready, 1);
        cyc();
        rsp_ready = 4'b0000;
        hs_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            hs_cnt += $countones(req_ready & req_valid);
            cyc();
        end
        chk("credit_refill_handshakes", hs_cnt, 1);
        chk("credit_outstanding_refull", outstanding, 8);

        // Back-pressure on the issue side
        do_reset();
        req_valid = 4'b0010;
        cyc();
        chk("bp_issue_valid", pt_in_valid, 1);
        chk("bp_issue_channel", pt_in_channel, 1);
        pt_in_ready = 1'b0;
        req_valid   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_req_ready", k), req_ready, 0);
            chk($sformatf("bp%0d_channel", k), pt_in_channel, 1);
            chk($sformatf("bp%0d_data", k), pt_in_data, mkreq(1));
            cyc();
            chk($sformatf("bp%0d_valid", k), pt_in_valid, 1);
        end
        pt_in_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0100);
        cyc();
        chk("bp_next_channel", pt_in_channel, 2);

        // Underflow sets route_err; reset mid-stream clears everything
        do_reset();
        pt_out_valid   = 1'b1;
        pt_out_channel = 2'd1;
        rsp_ready      = 4'b1111;
        cyc();
        chk("underflow_route_err", route_err, 1);
        chk("underflow_outstanding", outstanding, 0);
        pt_out_valid = 1'b0;
        cyc();
        chk("underflow_sticky", route_err, 1);
        req_valid   = 4'b1111;
        pt_in_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        req_valid   = 4'b0000;
        pt_in_ready = 1'b0;
        cyc();
        chk("mid_outstanding", outstanding, 3);
        chk("mid_pt_in_valid", pt_in_valid, 1);
        chk("mid_pt_in_channel", pt_in_channel, 2);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_pt_in_valid", pt_in_valid, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_route_err", route_err, 0);
        req_valid   = 4'b0101;
        pt_in_ready = 1'b1;
        @(negedge clk);
        chk("mid_first_grant", req_ready, 4'b0001);
        cyc();
        chk("mid_first_channel", pt_in_channel, 0);
        req_valid = 4'b0000;

        // Illegal channel on the NUM_REQ=5 instance
        b_req_valid = 5'b00001;
        @(negedge clk);
        chk("b_grant", b_req_ready, 5'b00001);
        cyc();
        b_req_valid = '0;
        chk("b_outstanding_one", b_outstanding, 1);
        b_pt_out_valid   = 1'b1;
        b_pt_out_channel = 3'd5;
        b_rsp_ready      = 5'b00000;
        @(negedge clk);
        chk("b_illegal_pt_out_ready", b_pt_out_ready, 1);
        chk("b_illegal_rsp_valid", b_rsp_valid, 0);
        cyc();
        b_pt_out_valid = 1'b0;
        chk("b_route_err_set", b_route_err, 1);
        chk("b_outstanding_dec", b_outstanding, 0);
        cyc();
        chk("b_route_err_sticky", b_route_err, 1);
        do_reset();
        chk("b_route_err_cleared", b_route_err, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
